usb_spectrum_tx: RTL and testbench

Streams a stored channel-count spectrum to the host through the USB write port of the ISP1362 bridge, complementing the USB command/read path that delivers `cmd_start`/`cmd_pause`/`cmd_clear` to the design. On a dump request it walks every channel address and reads each 32-bit count from the spectrum memory. It emits a framed sequence of 16-bit words on `usb_write_data`/`usb_write_en`, honouring `usb_write_wait` backpressure. It sits between the spectrum memory read port and the `usb_write_*` inputs of the ISP1362 bridge.

---
 rtl/usb_spectrum_tx.sv | 168 ++++++++++++++++
 tb/tb_usb_spectrum_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_spectrum_tx.sv
// usb_spectrum_tx
// Streams a stored channel-count spectrum to the host over the ISP1362 USB
// write port. A dump_req starts one frame:
//   HEADER, N_CH[15:0], {count[15:0], count[31:16]} x N_CH, checksum
// The checksum is the 16-bit wrapping sum of the 2*N_CH payload words only.
//
// Ports:
//   CLOCK_50        in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   dump_req        in   single-cycle frame request (ignored while busy)
//   abort           in   terminates the current frame, no done
//   channel_address out  spectrum memory read address (held between fetches)
//   channel_count   in   memory data, valid one cycle after the address
//   usb_write_data  out  word to the bridge
//   usb_write_en    out  word valid
//   usb_write_wait  in   bridge backpressure; a word moves when en && !wait
//   busy            out  frame in progress
//   done            out  one-cycle pulse after the checksum is accepted
module usb_spectrum_tx #(
  parameter int          N_CH   = 1024,
  parameter int          ADDR_W = 10,
  parameter logic [15:0] HEADER = 16'hA55A
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              dump_req,
  input  logic              abort,
  output logic [ADDR_W-1:0] channel_address,
  input  logic [31:0]       channel_count,
  output logic [15:0]       usb_write_data,
  output logic              usb_write_en,
  input  logic              usb_write_wait,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LEN   = 3'd2,
    FETCH = 3'd3,
    CAP   = 3'd4,
    LO    = 3'd5,
    HI    = 3'd6,
    SUM   = 3'd7
  } state_t;

  // One extra counter bit so the last-channel compare cannot alias when
  // N_CH fills the whole address space.
  localparam logic [ADDR_W:0] LAST_CH  = (ADDR_W+1)'(N_CH - 1);
  localparam logic [15:0]     LEN_WORD = 16'(N_CH);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   ch_reg, ch_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       hold_reg, hold_next;
  logic [15:0]       sum_reg, sum_next;
  logic              done_reg, done_next;
  logic              accept;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      addr_reg  <= '0;
      hold_reg  <= '0;
      sum_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      addr_reg  <= addr_next;
      hold_reg  <= hold_next;
      sum_reg   <= sum_next;
      done_reg  <= done_next;
    end
  end

  // Word-presenting states drive en purely from state, so data/en stay
  // stable for as long as the bridge holds wait high.
  always_comb begin
    usb_write_en = (state_reg == HDR) || (state_reg == LEN) ||
                   (state_reg == LO)  || (state_reg == HI)  ||
                   (state_reg == SUM);
  end

  assign accept = usb_write_en && !usb_write_wait;

  always_comb begin
    state_next     = state_reg;
    ch_next        = ch_reg;
    addr_next      = addr_reg;
    hold_next      = hold_reg;
    sum_next       = sum_reg;
    done_next      = 1'b0;
    usb_write_data = 16'h0000;

    case (state_reg)
      IDLE: begin
        if (dump_req) begin
          state_next = HDR;
          ch_next    = '0;
          sum_next   = '0;
        end
      end
      HDR: begin
        usb_write_data = HEADER;
        if (accept) state_next = LEN;
      end
      LEN: begin
        usb_write_data = LEN_WORD;
        if (accept) begin
          state_next = FETCH;
          // Address is registered on entry to FETCH so the memory sees it
          // throughout FETCH and returns data during CAP.
          addr_next  = ch_reg[ADDR_W-1:0];
        end
      end
      FETCH: begin
        state_next = CAP;
      end
      CAP: begin
        hold_next  = channel_count;
        state_next = LO;
      end
      LO: begin
        usb_write_data = hold_reg[15:0];
        if (accept) begin
          sum_next   = sum_reg + hold_reg[15:0];
          state_next = HI;
        end
      end
      HI: begin
        usb_write_data = hold_reg[31:16];
        if (accept) begin
          sum_next = sum_reg + hold_reg[31:16];
          if (ch_reg == LAST_CH) begin
            state_next = SUM;
          end else begin
            ch_next    = ch_reg + 1'b1;
            addr_next  = ch_next[ADDR_W-1:0];
            state_next = FETCH;
          end
        end
      end
      SUM: begin
        usb_write_data = sum_reg;
        if (accept) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort dominates everything, including a coincident dump_req in IDLE
    // and a checksum accept (no done for an aborted frame).
    if (abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
    end
  end

  assign channel_address = addr_reg;
  assign busy            = (state_reg != IDLE);
  assign done            = done_reg;

endmodule

// File: tb/tb_usb_spectrum_tx.sv
module tb_usb_spectrum_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- N_CH=4 instance ----------------
  logic [1:0]  addr4;
  logic [31:0] count4 = 32'h0;
  logic [15:0] data4;
  logic        en4, busy4, done4;
  logic        dump_req4 = 1'b0;
  logic        abort4 = 1'b0;
  logic        wait4 = 1'b0;
  logic [31:0] mem4 [4];

  usb_spectrum_tx #(.N_CH(4), .ADDR_W(2), .HEADER(16'hA55A)) dut4 (
    .CLOCK_50(clk), .rst(rst), .dump_req(dump_req4), .abort(abort4),
    .channel_address(addr4), .channel_count(count4),
    .usb_write_data(data4), .usb_write_en(en4), .usb_write_wait(wait4),
    .busy(busy4), .done(done4)
  );

  always @(posedge clk) count4 <= mem4[addr4];

  // ---------------- N_CH=1024 instance ----------------
  logic [9:0]  addr1k;
  logic [31:0] count1k = 32'h0;
  logic [15:0] data1k;
  logic        en1k, busy1k, done1k;
  logic        dump_req1k = 1'b0;
  logic        abort1k = 1'b0;
  logic        wait1k = 1'b0;

  usb_spectrum_tx #(.N_CH(1024), .ADDR_W(10), .HEADER(16'hA55A)) dut1k (
    .CLOCK_50(clk), .rst(rst), .dump_req(dump_req1k), .abort(abort1k),
    .channel_address(addr1k), .channel_count(count1k),
    .usb_write_data(data1k), .usb_write_en(en1k), .usb_write_wait(wait1k),
    .busy(busy1k), .done(done1k)
  );

  always @(posedge clk) count1k <= {22'd0, addr1k};

  // ---------------- monitors (sample on falling edge) ----------------
  logic [15:0] words4 [$];
  int          busy_cnt4, done_cnt4, done_busy4, stall_viol4;
  logic        prev_stall4 = 1'b0;
  logic [15:0] prev_data4 = 16'h0;

  always @(negedge clk) begin
    if (en4 && !wait4) words4.push_back(data4);
    if (prev_stall4 && (!en4 || data4 !== prev_data4)) stall_viol4++;
    prev_stall4 = en4 && wait4 && !abort4 && !rst;
    prev_data4  = data4;
    if (busy4) busy_cnt4++;
    if (done4) begin
      done_cnt4++;
      if (busy4) done_busy4++;
    end
  end

  logic [15:0] words1k [$];
  int          busy_cnt1k, done_cnt1k;
  logic [9:0]  max_addr1k = 10'd0;

  always @(negedge clk) begin
    if (en1k && !wait1k) words1k.push_back(data1k);
    if (busy1k) busy_cnt1k++;
    if (done1k) done_cnt1k++;
    if (busy1k && addr1k > max_addr1k) max_addr1k = addr1k;
  end

  logic [15:0] exp4 [11] = '{16'hA55A, 16'h0004, 16'h0002, 16'h0001,
                             16'h0003, 16'h0000, 16'h0000, 16'hFFFF,
                             16'h5678, 16'h1234, 16'h68B1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon4();
    words4.delete();
    busy_cnt4 = 0;
    done_cnt4 = 0;
    done_busy4 = 0;
    stall_viol4 = 0;
  endtask

  // Pulses dump_req on dut4 and runs until done (bounded). Optional stalls on
  // word index 4 and index 10, and an optional second dump_req at loop cycle.
  task automatic run_frame4(input int w5, input int wsum, input int extra_req,
                            output bit timed_out);
    int st5, sts, idx;
    st5 = 0;
    sts = 0;
    timed_out = 1'b1;
    clear_mon4();
    dump_req4 = 1'b1;
    tick();
    dump_req4 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      dump_req4 = (c == extra_req);
      idx = words4.size();
      if (en4 && idx == 4 && st5 < w5) begin
        wait4 = 1'b1;
        st5++;
      end else if (en4 && idx == 10 && sts < wsum) begin
        wait4 = 1'b1;
        sts++;
      end else begin
        wait4 = 1'b0;
      end
      tick();
      if (done4) begin
        timed_out = 1'b0;
        break;
      end
    end
    dump_req4 = 1'b0;
    wait4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checks += 5;
    if (addr4 !== 2'd0)   begin errors++; $display("FAIL reset_addr got=%h exp=0", addr4); end
    if (data4 !== 16'h0)  begin errors++; $display("FAIL reset_data got=%h exp=0000", data4); end
    if (en4 !== 1'b0)     begin errors++; $display("FAIL reset_en got=%b exp=0", en4); end
    if (busy4 !== 1'b0)   begin errors++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    if (done4 !== 1'b0)   begin errors++; $display("FAIL reset_done got=%b exp=0", done4); end
    $display("reset: addr=%h data=%h en=%b busy=%b done=%b", addr4, data4, en4, busy4, done4);
  endtask

  task automatic test_basic_frame();
    bit to;
    int st5;
    // First-cycle latency check done by hand before the bounded run.
    clear_mon4();
    dump_req4 = 1'b1;
    tick();
    dump_req4 = 1'b0;
    checks += 3;
    if (en4 !== 1'b1)       begin errors++; $display("FAIL hdr_en got=%b exp=1", en4); end
    if (data4 !== 16'hA55A) begin errors++; $display("FAIL hdr_data got=%h exp=a55a", data4); end
    if (busy4 !== 1'b1)     begin errors++; $display("FAIL hdr_busy got=%b exp=1", busy4); end
    to = 1'b1;
    st5 = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (done4) begin to = 1'b0; st5 = c; break; end
    end
    checks += 5;
    if (to) begin errors++; $display("FAIL basic_timeout got=timeout exp=done"); end
    if (words4.size() != 11) begin errors++; $display("FAIL basic_len got=%0d exp=11", words4.size()); end
    if (busy_cnt4 != 19) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=19", busy_cnt4); end
    if (done_busy4 != 0) begin errors++; $display("FAIL basic_done_busy got=%0d exp=0", done_busy4); end
    tick();
    if (done4 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done4); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= words4.size() || words4[i] !== exp4[i]) begin
        errors++;
        $display("FAIL basic_word%0d got=%h exp=%h", i, (i < words4.size()) ? words4[i] : 16'hxxxx, exp4[i]);
      end
    end
    $display("basic: words=%0d busy_cycles=%0d done_count=%0d", words4.size(), busy_cnt4, done_cnt4);
  endtask

  task automatic test_backpressure();
    bit to;
    run_frame4(3, 1, -1, to);
    tick();
    checks += 5;
    if (to) begin errors++; $display("FAIL wait_timeout got=timeout exp=done"); end
    if (words4.size() != 11) begin errors++; $display("FAIL wait_len got=%0d exp=11", words4.size()); end
    if (busy_cnt4 != 23) begin errors++; $display("FAIL wait_busy_cycles got=%0d exp=23", busy_cnt4); end
    if (stall_viol4 != 0) begin errors++; $display("FAIL wait_stable got=%0d exp=0", stall_viol4); end
    if (done_cnt4 != 1) begin errors++; $display("FAIL wait_done_count got=%0d exp=1", done_cnt4); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= words4.size() || words4[i] !== exp4[i]) begin
        errors++;
        $display("FAIL wait_word%0d got=%h exp=%h", i, (i < words4.size()) ? words4[i] : 16'hxxxx, exp4[i]);
      end
    end
    $display("backpressure: words=%0d busy_cycles=%0d", words4.size(), busy_cnt4);
  endtask

  task automatic test_back_to_back();
    bit to;
    run_frame4(0, 0, 5, to);
    repeat (30) tick();
    checks += 4;
    if (to) begin errors++; $display("FAIL b2b_timeout got=timeout exp=done"); end
    if (words4.size() != 11) begin errors++; $display("FAIL b2b_len got=%0d exp=11", words4.size()); end
    if (done_cnt4 != 1) begin errors++; $display("FAIL b2b_done_count got=%0d exp=1", done_cnt4); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL b2b_busy_after got=%b exp=0", busy4); end
    $display("back_to_back: words=%0d done_count=%0d", words4.size(), done_cnt4);
  endtask

  task automatic test_abort();
    bit to, found;
    clear_mon4();
    found = 1'b0;
    dump_req4 = 1'b1;
    tick();
    dump_req4 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (en4 && words4.size() == 6) begin found = 1'b1; break; end
      tick();
    end
    checks += 2;
    if (!found) begin errors++; $display("FAIL abort_reach got=timeout exp=ch2_lo"); end
    if (data4 !== 16'h0000) begin errors++; $display("FAIL abort_ch2lo_data got=%h exp=0000", data4); end
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    checks += 2;
    if (en4 !== 1'b0)   begin errors++; $display("FAIL abort_en got=%b exp=0", en4); end
    if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy4); end
    repeat (5) tick();
    checks++;
    if (done_cnt4 != 0) begin errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt4); end
    // abort wins over a coincident dump_req in IDLE
    dump_req4 = 1'b1;
    abort4 = 1'b1;
    tick();
    dump_req4 = 1'b0;
    abort4 = 1'b0;
    checks++;
    if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_vs_req got=%b exp=0", busy4); end
    run_frame4(0, 0, -1, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL abort_refr_timeout got=timeout exp=done"); end
    if (words4.size() != 11) begin errors++; $display("FAIL abort_refr_len got=%0d exp=11", words4.size()); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= words4.size() || words4[i] !== exp4[i]) begin
        errors++;
        $display("FAIL abort_refr_word%0d got=%h exp=%h", i, (i < words4.size()) ? words4[i] : 16'hxxxx, exp4[i]);
      end
    end
    $display("abort: refreshed frame words=%0d", words4.size());
  endtask

  task automatic test_rst_mid_frame();
    bit to, found;
    clear_mon4();
    found = 1'b0;
    dump_req4 = 1'b1;
    tick();
    dump_req4 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (en4 && words4.size() == 5) begin found = 1'b1; break; end
      tick();
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rst_reach got=timeout exp=ch1_hi"); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks += 5;
    if (addr4 !== 2'd0)  begin errors++; $display("FAIL rst_addr got=%h exp=0", addr4); end
    if (data4 !== 16'h0) begin errors++; $display("FAIL rst_data got=%h exp=0000", data4); end
    if (en4 !== 1'b0)    begin errors++; $display("FAIL rst_en got=%b exp=0", en4); end
    if (busy4 !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b exp=0", busy4); end
    if (done4 !== 1'b0)  begin errors++; $display("FAIL rst_done got=%b exp=0", done4); end
    run_frame4(0, 0, -1, to);
    checks += 2;
    if (to) begin errors++; $display("FAIL rst_refr_timeout got=timeout exp=done"); end
    if (words4.size() != 11) begin errors++; $display("FAIL rst_refr_len got=%0d exp=11", words4.size()); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (i >= words4.size() || words4[i] !== exp4[i]) begin
        errors++;
        $display("FAIL rst_refr_word%0d got=%h exp=%h", i, (i < words4.size()) ? words4[i] : 16'hxxxx, exp4[i]);
      end
    end
    $display("rst_mid_frame: refreshed frame words=%0d", words4.size());
  endtask

  task automatic test_full_1024();
    bit to;
    int bad;
    words1k.delete();
    busy_cnt1k = 0;
    done_cnt1k = 0;
    max_addr1k = 10'd0;
    dump_req1k = 1'b1;
    tick();
    dump_req1k = 1'b0;
    to = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      tick();
      if (done1k) begin to = 1'b0; break; end
    end
    checks += 7;
    if (to) begin errors++; $display("FAIL n1k_timeout got=timeout exp=done"); end
    if (words1k.size() != 2051) begin errors++; $display("FAIL n1k_len got=%0d exp=2051", words1k.size()); end
    if (busy_cnt1k != 4099) begin errors++; $display("FAIL n1k_busy_cycles got=%0d exp=4099", busy_cnt1k); end
    if (max_addr1k !== 10'h3FF) begin errors++; $display("FAIL n1k_max_addr got=%h exp=3ff", max_addr1k); end
    if (addr1k !== 10'h3FF) begin errors++; $display("FAIL n1k_final_addr got=%h exp=3ff", addr1k); end
    if (words1k.size() < 2 || words1k[1] !== 16'h0400) begin
      errors++; $display("FAIL n1k_len_word got=%h exp=0400", (words1k.size() > 1) ? words1k[1] : 16'hxxxx);
    end
    if (words1k.size() != 2051 || words1k[2050] !== 16'hFE00) begin
      errors++; $display("FAIL n1k_checksum got=%h exp=fe00", (words1k.size() == 2051) ? words1k[2050] : 16'hxxxx);
    end
    bad = 0;
    if (words1k.size() == 2051) begin
      for (int i = 0; i < 1024; i++) begin
        if (words1k[2 + 2*i] !== 16'(i) || words1k[3 + 2*i] !== 16'h0000) bad++;
      end
    end else begin
      bad = 1024;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL n1k_payload got=%0d bad_channels exp=0", bad); end
    $display("full_1024: words=%0d busy_cycles=%0d max_addr=%h", words1k.size(), busy_cnt1k, max_addr1k);
  endtask

  initial begin
    mem4[0] = 32'h00010002;
    mem4[1] = 32'h00000003;
    mem4[2] = 32'hFFFF0000;
    mem4[3] = 32'h12345678;
    clear_mon4();
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_rst_mid_frame();
    test_full_1024();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
